// File: rtl/serial_add_sequencer.sv
// Sequencer feeding a single-bit Mealy serial adder and collecting its sum.
// Optional SERIAL_SUB_EN adds the sub port and a carry-priming cycle.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             add_a,
  output logic             add_b,
  output logic             add_en,
  output logic             add_clr,
  input  logic             add_s
);

`ifdef SERIAL_SUB_EN
  typedef enum logic [2:0] {
    IDLE, CLEAR, PRIME, SHIFT, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CLEAR, SHIFT, DONE
  } state_t;
`endif

  localparam logic [5:0] LAST = 6'(WIDTH);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH:0]   res;
  logic [5:0]       cnt;
`ifdef SERIAL_SUB_EN
  logic             sub_q;
`endif

  assign sum = res;

  always_comb begin
    nxt     = state;
    busy    = (state != IDLE);
    done    = 1'b0;
    add_a   = 1'b0;
    add_b   = 1'b0;
    add_en  = 1'b0;
    add_clr = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = CLEAR;
      CLEAR: begin
        add_clr = 1'b1;
`ifdef SERIAL_SUB_EN
        nxt = sub_q ? PRIME : SHIFT;
`else
        nxt = SHIFT;
`endif
      end
`ifdef SERIAL_SUB_EN
      PRIME: begin
        add_en = 1'b1;
        add_a  = 1'b1;
        add_b  = 1'b1;
        nxt    = SHIFT;
      end
`endif
      SHIFT: begin
        add_en = 1'b1;
        // last cycle feeds zeros so add_s carries the carry-out
        if (cnt != LAST) begin
          add_a = a_sh[0];
          add_b = b_sh[0];
        end else begin
          nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
`ifdef SERIAL_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        a_sh <= op_a;
        res  <= '0;
        cnt  <= '0;
`ifdef SERIAL_SUB_EN
        b_sh  <= sub ? ~op_b : op_b;
        sub_q <= sub;
`else
        b_sh <= op_b;
`endif
      end else if (state == SHIFT) begin
        res  <= {add_s, res[WIDTH:1]};
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        cnt  <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer with a behavioural serial adder and model.
// Honours SERIAL_SUB_EN when defined.
module tb_serial_add_sequencer;
  localparam int W = 8;
`ifdef SERIAL_SUB_EN
  localparam bit SUBEN = 1'b1;
`else
  localparam bit SUBEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         sub = 1'b0;
  logic         busy, done;
  logic [W:0]   sum;
  logic         add_a, add_b, add_en, add_clr, add_s;

  int checks = 0;
  int errors = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum),
    .add_a(add_a), .add_b(add_b),
    .add_en(add_en), .add_clr(add_clr),
    .add_s(add_s)
  );

  always #5 clk = ~clk;

  // serial adder: carry register with synchronous clear, starts stale
  logic carry = 1'b1;
  assign add_s = add_a ^ add_b ^ carry;
  always @(posedge clk)
    if (add_clr) carry <= 1'b0;
    else if (add_en)
      carry <= (add_a & add_b) | (carry & (add_a ^ add_b));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference model: operation timeline keyed on the accepting edge
  int         cyc = 0;
  int         s_edge = 0;
  int         len = 0;
  bit         active = 1'b0;
  bit         msub = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  logic [W:0] exp_sum = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      active  = 1'b0;
      exp_sum = '0;
    end else if (start && (!active || cyc - s_edge >= len + 1)) begin
      active = 1'b1;
      s_edge = cyc;
      msub   = SUBEN && sub;
      ma     = op_a;
      mb     = msub ? ~op_b : op_b;
      len    = W + 3 + int'(msub);
      if (msub)
        exp_sum = {op_a >= op_b, W'(op_a - op_b)};
      else
        exp_sum = (W+1)'(op_a) + (W+1)'(op_b);
    end
  end

  always @(negedge clk) begin
    int  c, k;
    bit  e_busy, e_done, e_clr, e_pr, e_sh, e_a, e_b;
    c = cyc - s_edge + 1;
    k = c - (msub ? 3 : 2);
    e_busy = active && c >= 1 && c <= len;
    e_done = active && c == len;
    e_clr  = active && c == 1;
    e_pr   = active && msub && c == 2;
    e_sh   = active && k >= 0 && k <= W;
    e_a    = e_pr || (e_sh && k < W && ma[k % W]);
    e_b    = e_pr || (e_sh && k < W && mb[k % W]);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("add_clr", 32'(add_clr), 32'(e_clr));
    chk("add_en", 32'(add_en), 32'(e_pr || e_sh));
    chk("add_a", 32'(add_a), 32'(e_a));
    chk("add_b", 32'(add_b), 32'(e_b));
    if (!active || c >= len)
      chk("sum", 32'(sum), 32'(exp_sum));
  end

  task automatic drive_op(input logic [W-1:0] a, b, input bit s);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        lat   = cyc - s_edge + 1;
      end
    end
    if (!found) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run(input logic [W-1:0] a, b, input bit s,
                     input logic [W:0] want, input string nm);
    int lat;
    drive_op(a, b, s);
    wait_done(lat);
    chk(nm, 32'(sum), 32'(want));
    chk({nm, "_lat"}, 32'(lat), 32'(W + 3 + int'(s)));
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    rst = 1'b0;

    run(8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
    run(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    run(8'hFF, 8'hFF, 1'b0, 9'h1FE, "add_ff_ff");
    run(8'h80, 8'h80, 1'b0, 9'h100, "b2b_80_80");
    run(8'h01, 8'h01, 1'b0, 9'h002, "b2b_01_01");

    // start held through busy with changing operands
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22;
    wait_done(lat);
    chk("held_sum", 32'(sum), 32'h046);
    chk("held_lat", 32'(lat), 32'(W + 3));
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("held_reaccept", 32'(busy), 32'(1));
    wait_done(lat);
    chk("held_second", 32'(sum), 32'h033);

    // asynchronous reset mid-shift
    drive_op(8'h77, 8'h66, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_en", 32'(add_en), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_outs",
        32'({busy, done, add_a, add_b, add_en, add_clr}), 32'(0));
    chk("arst_sum", 32'(sum), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    run(8'h03, 8'h04, 1'b0, 9'h007, "post_rst");

    if (SUBEN) begin
      run(8'h10, 8'h01, 1'b1, 9'h10F, "sub_10_01");
      run(8'h01, 8'h02, 1'b1, 9'h0FF, "sub_01_02");
    end

    for (int n = 0; n < 150; n++) begin
      int h;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      sub   = SUBEN && ($urandom_range(0, 1) == 1);
      h     = $urandom_range(1, 3);
      for (int j = 0; j < h; j++) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        wait_done(lat);
        chk("rand_lat", 32'(lat), 32'(len));
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Upstream/downstream controller for the team's single-bit Mealy serial adder. Accepts two parallel WIDTH-bit operands on a start handshake, clears the adder's carry state, and streams operand bits LSB-first into the adder. It then shifts the adder's sum bits back into a parallel WIDTH+1-bit result and pulses done. It owns the adder's A, B, en and rst inputs and consumes its S output.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock, shared with the serial adder
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A; captured on the accepted start
- op_b  input  WIDTH  operand B; captured on the accepted start
- sub  input  1  subtract request; sampled with start; present only with SERIAL_SUB_EN
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; sum is valid
- sum  output  WIDTH+1  result; bit WIDTH is the carry-out
- add_a  output  1  to adder A
- add_b  output  1  to adder B
- add_en  output  1  to adder en
- add_clr  output  1  to adder rst; the adder's reset is synchronous
- add_s  input  1  from adder S; combinational, a function of add_a, add_b and adder state

## Operation
- States: IDLE, CLEAR, PRIME (SERIAL_SUB_EN only), SHIFT, DONE.
- IDLE:
  - start=1 loads a_sh<=op_a, b_sh<=op_b (or ~op_b when sub=1), cnt<=0, and clears the result shift register.
  - Next state is CLEAR.
- CLEAR:
  - add_clr=1, add_en=0, for exactly one cycle.
  - Adder carry state is 0 after this edge.
  - Next state is PRIME if sub was latched, else SHIFT.
- PRIME:
  - add_en=1, add_a=1, add_b=1, for one cycle.
  - Drives the adder carry state to 1; add_s is ignored.
  - Next state is SHIFT.
- SHIFT:
  - add_en=1, add_a=a_sh[0], add_b=b_sh[0].
  - On each edge: res <= {add_s, res[WIDTH:1]}; a_sh and b_sh shift right with 0 fill; cnt <= cnt+1.
  - cnt runs 0..WIDTH, giving WIDTH+1 bit cycles.
  - On cnt==WIDTH (the final carry-extract cycle), add_a=0 and add_b=0 regardless of register contents, so add_s equals the carry.
  - After that cycle, next state is DONE.
- DONE:
  - done=1, add_en=0, for one cycle.
  - sum=res; sum holds until the next accepted start.
  - Next state is IDLE.
- In IDLE, CLEAR and DONE, add_en=0, so adder state is frozen.
- add_a and add_b are 0 outside SHIFT/PRIME.
- start while busy is ignored; there is no queueing.
- Arithmetic:
  - Add: sum = op_a + op_b, (WIDTH+1)-bit exact.
  - Subtract: sum[WIDTH-1:0] = (op_a - op_b) mod 2^WIDTH; sum[WIDTH]=1 means no borrow (op_a >= op_b).

## Timing
- Reset values: all outputs 0, sum=0, state IDLE, cnt=0.
- Reset mid-operation aborts immediately, with no done pulse.
  - The adder's carry may be stale afterwards; the next operation's CLEAR handles it.
- Let edge 0 be the edge that samples start.
  - CLEAR: cycle 1.
  - SHIFT: cycles 2..WIDTH+2 (add). With PRIME in cycle 2 (subtract), SHIFT shifts by one cycle.
  - done: cycle WIDTH+3 for add, WIDTH+4 for subtract.
- busy rises the cycle after the accepted start and falls together with the end of the done pulse.
- A back-to-back start is accepted in the cycle after done.
- add_s is sampled on the same rising edge on which the adder advances its state.
- Outputs add_a, add_b, add_en and add_clr are registered-state decodes, glitch-free with respect to clk.

## Configuration
- SERIAL_SUB_EN:
  - Defined: adds the sub port and the PRIME state; subtraction is supported.
  - Undefined: no sub port, no PRIME state; the block is add-only and CLEAR always goes to SHIFT.

## Test plan
- WIDTH=8, op_a=0x5A, op_b=0x3C, start one cycle -> sum=0x096; done exactly 11 cycles after the start edge; busy high for cycles 1..11.
- op_a=0xFF, op_b=0x01 -> sum=0x100; op_a=0xFF, op_b=0xFF -> sum=0x1FE.
- start held high with new operands during busy -> ignored; result from the first operands; next start accepted in the cycle after done.
- Assert rst in SHIFT cycle 5 -> busy, done, sum and add_* outputs are 0 asynchronously. Following op 0x03+0x04 -> sum=0x007, showing the carry was cleared.
- SERIAL_SUB_EN: 0x10-0x01 -> sum=0x10F; 0x01-0x02 -> sum=0x0FF; done at start+12.
- Two adds back-to-back (0x80+0x80 then 0x01+0x01) -> 0x100 then 0x002; no carry leakage between operations.
